// File: rtl/axis_hdr_pkg.sv
// Shared state encoding and keep-vector helpers for the AXI-Stream header stripper.
// Helpers work on a wide fixed vector so any bus width up to KEEP_MAX bytes can use them.
package axis_hdr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BODY  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam int KEEP_MAX = 64;
    typedef logic [KEEP_MAX-1:0] kmax_t;

    function automatic logic [7:0] count_ones(input kmax_t k, input int w);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < KEEP_MAX; i++)
            if (i < w && k[i]) c = c + 8'd1;
        return c;
    endfunction

    // Mask with the top n bits of a w-bit keep field set.
    function automatic kmax_t keep_top(input int n, input int w);
        kmax_t m;
        m = '0;
        for (int i = 0; i < KEEP_MAX; i++)
            m[i] = (i < w) && (i >= w - n);
        return m;
    endfunction

endpackage

// File: rtl/axis_byte_align.sv
// Combinational byte realignment: glues the low rcnt bytes of the residue above the
// top bytes of the current beat, zeroes bytes not qualified by keep_i.
module axis_byte_align
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic [DATA_WD-1:0]      residue_i,
    input  logic [DATA_WD-1:0]      data_i,
    input  logic [BYTE_CNT_WD-1:0]  rcnt_i,
    input  logic [DATA_BYTE_WD-1:0] keep_i,
    output logic [DATA_WD-1:0]      data_o,
    output logic [DATA_WD-1:0]      residue_o
);

    localparam logic [DATA_WD-1:0] ONES = '1;

    int                 sh_lo;
    int                 sh_hi;
    logic [DATA_WD-1:0] merged;

    // rcnt_i == 0 gives sh_hi == DATA_WD, so the residue term and mask drop to zero.
    always_comb begin
        sh_lo     = 8 * int'(rcnt_i);
        sh_hi     = 8 * (DATA_BYTE_WD - int'(rcnt_i));
        merged    = (residue_i << sh_hi) | (data_i >> sh_lo);
        residue_o = data_i & (ONES >> sh_hi);
    end

    for (genvar b = 0; b < DATA_BYTE_WD; b++) begin : g_lane
        assign data_o[8*b +: 8] = keep_i[b] ? merged[8*b +: 8] : 8'h00;
    end

endmodule

// File: rtl/axi_stream_strip_header.sv
// Splits the leading N bytes of each AXI-Stream packet onto a header port and
// re-packs the remaining payload MSB-first onto the output stream.
module axi_stream_strip_header
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output logic                    valid_header,
    output logic [DATA_WD-1:0]      data_header,
    output logic [DATA_BYTE_WD-1:0] keep_header,
    input  logic                    ready_header,
    input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt
);

    localparam int               SUM_W = BYTE_CNT_WD + 2;
    localparam logic [SUM_W-1:0] W_S   = SUM_W'(DATA_BYTE_WD);

    state_e                  state_q, state_d;
    logic [BYTE_CNT_WD-1:0]  rcnt_q, rcnt_d, rcnt_new, rcnt_use;
    logic [SUM_W-1:0]        fcnt_q, fcnt_d, kin, tot, kc;
    logic [DATA_WD-1:0]      residue_q, residue_d;
    logic                    valid_out_q, valid_out_d, last_out_q, last_out_d;
    logic [DATA_WD-1:0]      data_out_q, data_out_d;
    logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d, keep_sel;
    logic                    valid_header_q, valid_header_d;
    logic [DATA_WD-1:0]      data_header_q, data_header_d;
    logic [DATA_BYTE_WD-1:0] keep_header_q, keep_header_d;
    logic                    out_free, hdr_free, acc;
    logic [DATA_WD-1:0]      al_res, al_dat, al_data, al_resid;

    // Residue count R = W - N; only the first beat samples byte_strip_cnt.
    assign rcnt_new = BYTE_CNT_WD'(DATA_BYTE_WD - 1) - byte_strip_cnt;
    assign rcnt_use = (state_q == ST_IDLE) ? rcnt_new : rcnt_q;

    assign out_free = !valid_out_q || ready_out;
    assign hdr_free = !valid_header_q || ready_header;
    assign ready_in = rst_n && (state_q != ST_FLUSH) && out_free &&
                      ((state_q != ST_IDLE) || hdr_free);
    assign acc      = valid_in && ready_in;

    assign kin = SUM_W'(count_ones(kmax_t'(keep_in), DATA_BYTE_WD));
    assign tot = SUM_W'(rcnt_use) + kin;

    // Valid byte count of the beat being loaded into the output register.
    always_comb begin
        case (state_q)
            ST_IDLE: kc = tot - W_S;
            ST_BODY: kc = (last_in && tot <= W_S) ? tot : W_S;
            default: kc = fcnt_q;
        endcase
        keep_sel = DATA_BYTE_WD'(keep_top(int'(kc), DATA_BYTE_WD));
    end

    // In IDLE the first beat feeds both ports; its low R bytes land on top and the
    // rest is masked off since at most R payload bytes can follow the header.
    assign al_res = (state_q == ST_IDLE) ? data_in : residue_q;
    assign al_dat = (state_q == ST_FLUSH) ? '0 : data_in;

    axis_byte_align #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .BYTE_CNT_WD  (BYTE_CNT_WD)
    ) u_align (
        .residue_i (al_res),
        .data_i    (al_dat),
        .rcnt_i    (rcnt_use),
        .keep_i    (keep_sel),
        .data_o    (al_data),
        .residue_o (al_resid)
    );

    always_comb begin
        state_d        = state_q;
        rcnt_d         = rcnt_q;
        fcnt_d         = fcnt_q;
        residue_d      = residue_q;
        valid_out_d    = valid_out_q;
        data_out_d     = data_out_q;
        keep_out_d     = keep_out_q;
        last_out_d     = last_out_q;
        valid_header_d = valid_header_q;
        data_header_d  = data_header_q;
        keep_header_d  = keep_header_q;

        if (valid_out_q && ready_out)       valid_out_d    = 1'b0;
        if (valid_header_q && ready_header) valid_header_d = 1'b0;

        case (state_q)
            ST_IDLE: if (acc) begin
                valid_header_d = 1'b1;
                data_header_d  = data_in;
                keep_header_d  = DATA_BYTE_WD'(keep_top(DATA_BYTE_WD - int'(rcnt_new), DATA_BYTE_WD));
                rcnt_d         = rcnt_new;
                residue_d      = al_resid;
                if (!last_in) begin
                    state_d = ST_BODY;
                end else if (tot > W_S) begin
                    valid_out_d = 1'b1;
                    data_out_d  = al_data;
                    keep_out_d  = keep_sel;
                    last_out_d  = 1'b1;
                end
            end
            ST_BODY: if (acc) begin
                valid_out_d = 1'b1;
                data_out_d  = al_data;
                keep_out_d  = keep_sel;
                last_out_d  = last_in && (tot <= W_S);
                residue_d   = al_resid;
                if (last_in) begin
                    if (tot <= W_S) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FLUSH;
                        fcnt_d  = tot - W_S;
                    end
                end
            end
            default: if (out_free) begin
                // First free slot takes the residual beat; its handshake ends the packet.
                if (valid_out_q && last_out_q) begin
                    state_d = ST_IDLE;
                end else begin
                    valid_out_d = 1'b1;
                    data_out_d  = al_data;
                    keep_out_d  = keep_sel;
                    last_out_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            rcnt_q         <= '0;
            fcnt_q         <= '0;
            residue_q      <= '0;
            valid_out_q    <= 1'b0;
            data_out_q     <= '0;
            keep_out_q     <= '0;
            last_out_q     <= 1'b0;
            valid_header_q <= 1'b0;
            data_header_q  <= '0;
            keep_header_q  <= '0;
        end else begin
            state_q        <= state_d;
            rcnt_q         <= rcnt_d;
            fcnt_q         <= fcnt_d;
            residue_q      <= residue_d;
            valid_out_q    <= valid_out_d;
            data_out_q     <= data_out_d;
            keep_out_q     <= keep_out_d;
            last_out_q     <= last_out_d;
            valid_header_q <= valid_header_d;
            data_header_q  <= data_header_d;
            keep_header_q  <= keep_header_d;
        end
    end

    assign valid_out    = valid_out_q;
    assign data_out     = data_out_q;
    assign keep_out     = keep_out_q;
    assign last_out     = last_out_q;
    assign valid_header = valid_header_q;
    assign data_header  = data_header_q;
    assign keep_header  = keep_header_q;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Directed bench for the header stripper at W=4: hand-computed beats, immediate assertions.
module tb_axi_stream_strip_header;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, last_in, ready_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        valid_out, last_out, ready_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        valid_header, ready_header;
    logic [31:0] data_header;
    logic [3:0]  keep_header;
    logic [1:0]  bsc;

    int total = 0;
    int bad   = 0;

    logic [31:0] oq_d[$];
    logic [3:0]  oq_k[$];
    logic        oq_l[$];
    logic [31:0] hq_d[$];
    logic [3:0]  hq_k[$];

    axi_stream_strip_header #(.DATA_WD(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .data_in        (data_in),
        .keep_in        (keep_in),
        .last_in        (last_in),
        .ready_in       (ready_in),
        .valid_out      (valid_out),
        .data_out       (data_out),
        .keep_out       (keep_out),
        .last_out       (last_out),
        .ready_out      (ready_out),
        .valid_header   (valid_header),
        .data_header    (data_header),
        .keep_header    (keep_header),
        .ready_header   (ready_header),
        .byte_strip_cnt (bsc)
    );

    always #5 clk = ~clk;

    // Inputs only change just after posedge, so a negedge view is what the next edge samples.
    always @(negedge clk) begin
        if (valid_out && ready_out) begin
            oq_d.push_back(data_out);
            oq_k.push_back(keep_out);
            oq_l.push_back(last_out);
        end
        if (valid_header && ready_header) begin
            hq_d.push_back(data_header);
            hq_k.push_back(keep_header);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, output int waited);
        valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
        waited = 0;
        @(negedge clk);
        while (!ready_in && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("send_accept", 64'(ready_in), 64'd1);
        @(posedge clk); #1;
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
        int t = 0;
        while (oq_d.size() == 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_present"}, 64'(oq_d.size() != 0), 64'd1);
        if (oq_d.size() != 0) begin
            chk({tag, "_data"}, 64'(oq_d.pop_front()), 64'(d));
            chk({tag, "_keep"}, 64'(oq_k.pop_front()), 64'(k));
            chk({tag, "_last"}, 64'(oq_l.pop_front()), 64'(l));
        end
    endtask

    task automatic expect_hdr(input string tag, input logic [31:0] d, input logic [3:0] k);
        int t = 0;
        while (hq_d.size() == 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_present"}, 64'(hq_d.size() != 0), 64'd1);
        if (hq_d.size() != 0) begin
            chk({tag, "_data"}, 64'(hq_d.pop_front()), 64'(d));
            chk({tag, "_keep"}, 64'(hq_k.pop_front()), 64'(k));
        end
    endtask

    task automatic expect_idle(input string tag);
        repeat (4) @(negedge clk);
        chk({tag, "_extra_out"}, 64'(oq_d.size()), 64'd0);
        chk({tag, "_extra_hdr"}, 64'(hq_d.size()), 64'd0);
    endtask

    initial begin
        int w;
        rst_n = 1'b0; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        ready_out = 1'b1; ready_header = 1'b1; bsc = 2'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid_out",    64'(valid_out),    64'd0);
        chk("rst_last_out",     64'(last_out),     64'd0);
        chk("rst_valid_header", 64'(valid_header), 64'd0);
        chk("rst_ready_in",     64'(ready_in),     64'd0);
        chk("rst_data_out",     64'(data_out),     64'd0);
        chk("rst_keep_out",     64'(keep_out),     64'd0);
        chk("rst_data_header",  64'(data_header),  64'd0);
        chk("rst_keep_header",  64'(keep_header),  64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 64'(ready_in), 64'd1);
        @(posedge clk); #1;

        // N=2, three beats, last beat fills exactly one output beat
        bsc = 2'd1;
        send(32'hAABB0102, 4'hF, 1'b0, w);
        send(32'h03040506, 4'hF, 1'b0, w);
        send(32'h07089999, 4'hC, 1'b1, w);
        expect_hdr("p1_hdr", 32'hAABB0102, 4'hC);
        expect_out("p1_o0", 32'h01020304, 4'hF, 1'b0);
        expect_out("p1_o1", 32'h05060708, 4'hF, 1'b1);
        expect_idle("p1");

        // N=1, residue overflows into a flush beat
        @(posedge clk); #1;
        bsc = 2'd0;
        send(32'hEE112233, 4'hF, 1'b0, w);
        send(32'h44556677, 4'hF, 1'b1, w);
        expect_hdr("p2_hdr", 32'hEE112233, 4'h8);
        expect_out("p2_o0", 32'h11223344, 4'hF, 1'b0);
        expect_out("p2_o1", 32'h55667700, 4'hE, 1'b1);
        expect_idle("p2");

        // N=4, whole first beat is header; short last beat zero-filled
        @(posedge clk); #1;
        bsc = 2'd3;
        send(32'hDEADBEEF, 4'hF, 1'b0, w);
        send(32'h11223344, 4'h8, 1'b1, w);
        expect_hdr("p3_hdr", 32'hDEADBEEF, 4'hF);
        expect_out("p3_o0", 32'h11000000, 4'h8, 1'b1);
        expect_idle("p3");

        // Single-beat header-only packet, then a single-beat packet with k>N right after
        @(posedge clk); #1;
        bsc = 2'd1;
        send(32'hAABBCCDD, 4'hC, 1'b1, w);
        bsc = 2'd0;
        send(32'h12345678, 4'hE, 1'b1, w);
        chk("b2b_wait_cycles", 64'(w), 64'd0);
        expect_hdr("p4_hdr", 32'hAABBCCDD, 4'hC);
        expect_hdr("p5_hdr", 32'h12345678, 4'h8);
        expect_out("p5_o0", 32'h34560000, 4'hC, 1'b1);
        expect_idle("p45");

        // Output backpressure for 5 cycles mid-packet
        @(posedge clk); #1;
        bsc = 2'd1; ready_out = 1'b0;
        send(32'h11220A0B, 4'hF, 1'b0, w);
        send(32'h0C0D0E0F, 4'hF, 1'b0, w);
        valid_in = 1'b1; data_in = 32'h10111213; keep_in = 4'hF; last_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ready_in",  64'(ready_in),  64'd0);
            chk("stall_valid_out", 64'(valid_out), 64'd1);
            chk("stall_data_out",  64'(data_out),  64'h0A0B0C0D);
            chk("stall_keep_out",  64'(keep_out),  64'hF);
            chk("stall_last_out",  64'(last_out),  64'd0);
        end
        @(posedge clk); #1;
        ready_out = 1'b1;
        send(32'h10111213, 4'hF, 1'b0, w);
        send(32'h14150000, 4'hC, 1'b1, w);
        expect_hdr("p6_hdr", 32'h11220A0B, 4'hC);
        expect_out("p6_o0", 32'h0A0B0C0D, 4'hF, 1'b0);
        expect_out("p6_o1", 32'h0E0F1011, 4'hF, 1'b0);
        expect_out("p6_o2", 32'h12131415, 4'hF, 1'b1);
        expect_idle("p6");

        // Reset in the middle of a packet, then a clean packet
        @(posedge clk); #1;
        bsc = 2'd0; ready_out = 1'b0;
        send(32'hCAFEBABE, 4'hF, 1'b0, w);
        send(32'h01020304, 4'hF, 1'b0, w);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid_out",    64'(valid_out),    64'd0);
        chk("mid_rst_last_out",     64'(last_out),     64'd0);
        chk("mid_rst_valid_header", 64'(valid_header), 64'd0);
        chk("mid_rst_ready_in",     64'(ready_in),     64'd0);
        chk("mid_rst_data_out",     64'(data_out),     64'd0);
        chk("mid_rst_keep_out",     64'(keep_out),     64'd0);
        chk("mid_rst_data_header",  64'(data_header),  64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; ready_out = 1'b1;
        oq_d.delete(); oq_k.delete(); oq_l.delete();
        hq_d.delete(); hq_k.delete();
        bsc = 2'd3;
        send(32'h99887766, 4'hF, 1'b0, w);
        send(32'hABCDEF01, 4'hF, 1'b1, w);
        expect_hdr("p7_hdr", 32'h99887766, 4'hF);
        expect_out("p7_o0", 32'hABCDEF01, 4'hF, 1'b1);
        expect_idle("p7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_stream_strip_header.md
AXI_STREAM_STRIP_HEADER -- requirements
Module: axi_stream_strip_header

Interface
REQ-001 SHALL have parameter DATA_WD, 32, stream data width in bits (multiple of 8).
REQ-002 SHALL have parameter DATA_BYTE_WD, DATA_WD/8, bytes per beat (W).
REQ-003 SHALL have parameter BYTE_CNT_WD, $clog2(DATA_BYTE_WD), header byte-count width.
REQ-004 SHALL have port clk input 1 sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n input 1 asynchronous active-low reset.
REQ-006 SHALL have ports valid_in input 1, data_in input DATA_WD, keep_in input DATA_BYTE_WD, last_in input 1, ready_in output 1: AXI-Stream packet in, header in first beat.
REQ-007 SHALL have ports valid_out output 1, data_out output DATA_WD, keep_out output DATA_BYTE_WD, last_out output 1, ready_out input 1: AXI-Stream payload out.
REQ-008 SHALL have ports valid_header output 1, data_header output DATA_WD, keep_header output DATA_BYTE_WD, ready_header input 1: extracted header.
REQ-009 SHALL have port byte_strip_cnt input BYTE_CNT_WD: header length N = byte_strip_cnt+1 bytes (1..W).

Function
REQ-010 SHALL order bytes MSB-first; keep bit i qualifies data byte i; keep_in SHALL be MSB-contiguous, all-ones on non-last beats.
REQ-011 SHALL sample byte_strip_cnt on the accepted first beat and hold N constant for the whole packet.
REQ-012 SHALL use states IDLE (await first beat), BODY (stream payload), FLUSH (emit residual beat); IDLE->BODY on first beat without last_in; BODY->FLUSH on last_in when R+k>W; BODY->IDLE on last_in when R+k<=W; FLUSH->IDLE on output handshake of flush beat.
REQ-013 SHALL present first beat's data on data_header with keep_header = top N bits set, valid_header held until ready_header.
REQ-014 SHALL hold first-beat ready_in low while the header register is occupied.
REQ-015 SHALL keep residue R = W-N bytes (low bytes of previous beat) in a register.
REQ-016 SHALL form each payload beat as {residue R bytes, top W-R bytes of current input}; new residue = low R bytes of current input.
REQ-017 SHALL for N=W (R=0) pass input beats unchanged through the output register.
REQ-018 SHALL on last_in with k valid bytes emit one beat, last_out=1, keep_out top (R+k) bits, if R+k<=W; else a full beat then FLUSH beat with keep top (R+k-W) bits, last_out=1.
REQ-019 SHALL for first beat with last_in and k<=N emit header only, no payload beat; if k>N emit one payload beat of k-N bytes, last_out=1.
REQ-020 SHALL drive invalid data_out bytes to zero.
REQ-021 SHALL register all outputs: one-cycle latency from input handshake to valid_out; sustain one beat per cycle when ready_out=1.
REQ-022 SHALL set ready_in = state!=FLUSH && (!valid_out || ready_out), plus REQ-014 in IDLE.
REQ-023 SHALL keep data_out/keep_out/last_out stable while valid_out=1 and ready_out=0.
REQ-024 SHALL accept a new packet's first beat in the cycle after the last output beat handshakes.

Reset
REQ-025 SHALL on rst_n low force valid_out, last_out, valid_header, ready_in to 0, data_out, keep_out, data_header, keep_header, residue to 0, state IDLE.
REQ-026 SHALL discard any packet in progress on reset; next accepted beat after release is a first beat.
REQ-027 SHALL drive ready_in high in the first cycle after reset release.

Structure
REQ-028 SHALL place state encoding and a count-ones/keep-mask function in shared package axis_hdr_pkg.
REQ-029 SHALL factor the byte concatenation/shift into combinational sub-module axis_byte_align.

Verification (W=4)
REQ-030 N=2: in 0xAABB0102, 0x03040506, 0x0708xxxx keep 1100 last -> header 0xAABB0102 keep 1100; out 0x01020304 keep 1111, 0x05060708 keep 1111 last.
REQ-031 N=1: in 0xEE112233, 0x44556677 keep 1111 last -> out 0x11223344 keep 1111, then 0x55667700 keep 1110 last (FLUSH).
REQ-032 N=4: in 0xDEADBEEF, 0x11223344 keep 1000 last -> header 0xDEADBEEF keep 1111; out 0x11000000 keep 1000 last.
REQ-033 N=2 single beat 0xAABBCCDD keep 1100 last -> header only, no valid_out; next packet accepted next cycle.
REQ-034 ready_out low 5 cycles mid-packet -> outputs stable, ready_in low, no byte lost/duplicated; rst_n low mid-packet -> all outputs 0, clean next packet.
